zymason_digit_bank: RTL
=======================

Name: zymason_digit_bank

Overview:
Parametrised successor to the single-size digit store/scan logic: a bank of NUM_DIGITS segment patterns of SEG_W bits each, with one shared position pointer. In write mode (rw=1) patterns load over a 4-bit nibble bus in two phases and the pointer auto-advances. In read mode (rw=0) the bank cycles the displayed digit at a programmable rate. Sits between the top-level pin wrapper and the output pins, driving seg_out from registered storage.

Parameters:
NUM_DIGITS, 12, number of stored digits (2..16)
SEG_W, 7, bits per stored pattern (5..8); low phase writes [3:0], high phase writes [SEG_W-1:4]
PRESCALE_W, 9, width of free-running prescaler; one tick every 2^PRESCALE_W clocks
SPD_W, 4, width of scan-speed input

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rw  input  1  1 = write mode, 0 = read/scan mode
sel  input  1  write phase select: 0 = low nibble, 1 = high part
clr  input  1  synchronous clear of all digits and pointer
pin_in  input  4  write data nibble
spd  input  SPD_W  scan period in ticks; 0 = scan halted
seg_out  output  SEG_W  pattern of digit at pointer
dig_idx  output  $clog2(NUM_DIGITS)  current pointer
pulse  output  1  one-cycle scan-advance strobe
mode_out  output  1  equals rw (combinational)

Behaviour:
- Reset (reset_n=0, async): state IDLE, pointer 0, all digits 0, prescaler 0, tick counter 0, pulse 0; seg_out=0, dig_idx=0.
- seg_out = digit[pointer], combinational from registers; zero added latency.
- FSM states IDLE, SCAN, WLO, WHI:
  IDLE: rw ? WLO : SCAN. SCAN: rw ? WLO : SCAN.
  WLO: !rw -> SCAN; else sel ? WHI : WLO.
  WHI: !rw -> SCAN; else sel ? WHI : WLO.
- Writes: in WLO or WHI with rw=1, sel=0: digit[ptr][3:0] <= pin_in every cycle. With rw=1, sel=1: digit[ptr][SEG_W-1:4] <= pin_in[SEG_W-5:0]; other pin_in bits ignored.
- Pointer advance in write mode: WHI with rw=1, sel=0 (falling sel) -> ptr increments; the low-nibble write that same cycle goes to the OLD ptr, matching the state-based write rule above.
- Prescaler free-runs, wraps at 2^PRESCALE_W; tick = (prescaler==0).
- Tick counter advances on tick only in SCAN with spd!=0. When tick and counter==spd-1: pulse=1 for exactly one cycle, counter <= 0, ptr advances. spd=0: counter held at 0, pulse never asserts. spd changed mid-count below counter: counter keeps counting up and wraps at 2^SPD_W, then matches again. No forced realignment.
- Counter cleared on any entry to WLO/WHI.
- Pointer wrap: NUM_DIGITS-1 -> 0 in both modes.
- clr=1 (synchronous, highest priority after reset): all digits 0, ptr 0, counter 0; FSM still follows its transitions; writes suppressed that cycle.
- Mode change mid-write: rw falling in WLO or WHI -> SCAN; ptr unchanged, partial data retained.

Optional Feature:
ZYMASON_BLANK_SKIP_EN: when defined, a scan pulse moves ptr to the next digit (cyclic, starting at ptr+1) whose pattern is non-zero. If every other digit is zero, ptr stays put. Write-mode advance is unaffected. When undefined, a scan pulse always moves to ptr+1 with wrap.

Test Plan:
- Reset mid-scan (ptr=5): assert reset_n=0 asynchronously -> seg_out=0, dig_idx=0, pulse=0 before the next clock edge.
- Write mode: rw=1, sel=0 with pin_in=4'hA; sel=1 with pin_in=4'h5; sel=0 -> digit0=7'h5A, dig_idx=1, seg_out then shows digit1.
- Write 12 digits, then one more full low/high/low sequence -> dig_idx wraps 11->0 and digit0 is overwritten.
- Scan with PRESCALE_W=3 override, spd=2, rw=0 -> pulse every 16 clocks, dig_idx 0,1,...,11,0. spd=0 -> pulse stays 0 for 200 clocks.
- clr=1 for one cycle after loading digits -> all reads return 0, dig_idx=0.
- With ZYMASON_BLANK_SKIP_EN, only digits 2 and 7 non-zero, ptr=2 -> successive pulses give 7, 2, 7. With all digits zero, ptr does not move.

Source files
------------

// File: rtl/zymason_digit_bank.sv
`default_nettype none
// ============================================================================
// Module   : zymason_digit_bank
// Brief    : Bank of NUM_DIGITS segment patterns with nibble-bus loading and
//            prescaled scan of the displayed digit. Optional blank-digit skip
//            on scan advance is enabled by defining ZYMASON_BLANK_SKIP_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module zymason_digit_bank #(
    parameter int NUM_DIGITS = 12,
    parameter int SEG_W      = 7,
    parameter int PRESCALE_W = 9,
    parameter int SPD_W      = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          rw,
    input  logic                          sel,
    input  logic                          clr,
    input  logic [3:0]                    pin_in,
    input  logic [SPD_W-1:0]              spd,
    output logic [SEG_W-1:0]              seg_out,
    output logic [$clog2(NUM_DIGITS)-1:0] dig_idx,
    output logic                          pulse,
    output logic                          mode_out
);

    localparam int PTR_W = $clog2(NUM_DIGITS);
    localparam int HI_W  = SEG_W - 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_WLO  = 2'd2;
    localparam logic [1:0] S_WHI  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [SEG_W-1:0]      r_digits [NUM_DIGITS];
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_ptr_inc;
    logic [PTR_W-1:0]      w_scan_next;
    logic [PRESCALE_W-1:0] r_presc;
    logic [SPD_W-1:0]      r_cnt;
    logic                  r_pulse;
    logic                  w_in_write;
    logic                  w_in_scan;
    logic                  w_write_next;
    logic                  w_advance_wr;
    logic                  w_tick;
    logic                  w_scan_fire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_SCAN: w_state_next = rw ? S_WLO : S_SCAN;
            S_WLO, S_WHI:   w_state_next = !rw ? S_SCAN : (sel ? S_WHI : S_WLO);
            default:        w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_write   = (r_state == S_WLO) || (r_state == S_WHI);
        w_in_scan    = (r_state == S_SCAN);
        w_write_next = (w_state_next == S_WLO) || (w_state_next == S_WHI);
        // Falling sel while in the high phase closes out the current digit
        w_advance_wr = (r_state == S_WHI) && rw && !sel;
    end

    assign w_tick      = (r_presc == '0);
    assign w_ptr_inc   = (r_ptr == PTR_W'(NUM_DIGITS - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_scan_fire = w_in_scan && (spd != '0) && w_tick && (r_cnt == spd - SPD_W'(1));

`ifdef ZYMASON_BLANK_SKIP_EN
    logic             w_found;
    logic [PTR_W:0]   w_probe;

    // First non-blank digit after the pointer, cyclically; stay if none
    always_comb begin
        w_scan_next = r_ptr;
        w_found     = 1'b0;
        w_probe     = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            w_probe = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_probe >= (PTR_W+1)'(NUM_DIGITS))
                w_probe = w_probe - (PTR_W+1)'(NUM_DIGITS);
            if (!w_found && (r_digits[w_probe[PTR_W-1:0]] != '0)) begin
                w_found     = 1'b1;
                w_scan_next = w_probe[PTR_W-1:0];
            end
        end
    end
`else
    assign w_scan_next = w_ptr_inc;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_presc <= '0;
        else          r_presc <= r_presc + PRESCALE_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                   r_cnt <= '0;
        else if (clr || w_write_next)   r_cnt <= '0;
        else if (spd == '0)             r_cnt <= '0;
        else if (w_scan_fire)           r_cnt <= '0;
        else if (w_in_scan && w_tick)   r_cnt <= r_cnt + SPD_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_pulse <= 1'b0;
        else          r_pulse <= w_scan_fire;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          r_ptr <= '0;
        else if (clr)          r_ptr <= '0;
        else if (w_advance_wr) r_ptr <= w_ptr_inc;
        else if (w_scan_fire)  r_ptr <= w_scan_next;
    end

    // The low-nibble write on an advancing cycle still targets the old pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_digits <= '{default: '0};
        end else if (clr) begin
            r_digits <= '{default: '0};
        end else if (w_in_write && rw) begin
            if (!sel) r_digits[r_ptr][3:0]       <= pin_in;
            else      r_digits[r_ptr][SEG_W-1:4] <= pin_in[HI_W-1:0];
        end
    end

    assign seg_out  = r_digits[r_ptr];
    assign dig_idx  = r_ptr;
    assign pulse    = r_pulse;
    assign mode_out = rw;

endmodule
`default_nettype wire
